// File: rtl/depunct_sync_ctrl_if.sv
// rtl/depunct_sync_ctrl_if.sv - decoder/deperforator link between the sync controller and its datapath
interface depunct_sync_ctrl_if;
    logic       i_dec_vld;
    logic       i_dec_err;
    logic       o_dec_rst_n;
    logic       o_sh_pointer;
    logic [2:0] o_llr_order;

    modport slave (
        input  i_dec_vld,
        input  i_dec_err,
        output o_dec_rst_n,
        output o_sh_pointer,
        output o_llr_order
    );

    modport master (
        output i_dec_vld,
        output i_dec_err,
        input  o_dec_rst_n,
        input  o_sh_pointer,
        input  o_llr_order
    );
endinterface

// File: rtl/depunct_sync_ctrl.sv
// rtl/depunct_sync_ctrl.sv - phase search / lock controller for the 1/2 deperforator and Fano decoder
module depunct_sync_ctrl #(
    parameter int FLUSH_LEN   = 16,
    parameter int LOCK_CNT    = 256,
    parameter int ACQ_ERR_MAX = 4,
    parameter int TIMEOUT     = 4096,
    parameter int WIN         = 1024,
    parameter int UNLOCK_ERR  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_cfg_en,
    input  logic [2:0]              i_cfg_llr_order,
    depunct_sync_ctrl_if.slave      dec_if,
    output logic                    o_locked,
    output logic                    o_phase,
    output logic [7:0]              o_slip_cnt
);

    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ACQ_ERR_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int WW = $clog2(WIN + 1);
    localparam int UW = $clog2(UNLOCK_ERR + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_ACQUIRE,
        S_LOCKED,
        S_SLIP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_llr_order;
    logic          r_phase;
    logic [7:0]    r_slip_cnt;
    logic [FW-1:0] r_flush_cnt;
    logic [GW-1:0] r_good_cnt;
    logic [EW-1:0] r_err_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic [WW-1:0] r_win_cnt;
    logic [UW-1:0] r_werr_cnt;

    logic w_vld;
    logic w_err;
    logic w_good;
    logic w_flush_done;
    logic w_lock_hit;
    logic w_acq_slip;
    logic w_wrap;
    logic w_unlock_hit;

    assign w_vld        = dec_if.i_dec_vld;
    assign w_err        = dec_if.i_dec_err;
    assign w_good       = w_vld & ~w_err;
    assign w_flush_done = (r_flush_cnt == FW'(FLUSH_LEN - 1));
    assign w_lock_hit   = w_good && (r_good_cnt == GW'(LOCK_CNT - 1));
    assign w_acq_slip   = (w_err && (r_err_cnt == EW'(ACQ_ERR_MAX - 1)))
                        || (r_tmo_cnt == TW'(TIMEOUT - 1));
    assign w_wrap       = w_vld && (r_win_cnt == WW'(WIN - 1));
    // An error on the wrap cycle belongs to the new window, so it cannot unlock the old one.
    assign w_unlock_hit = w_err && !w_wrap && (r_werr_cnt == UW'(UNLOCK_ERR - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = S_FLUSH;
            S_FLUSH:   if (w_flush_done) w_next = S_ACQUIRE;
            S_ACQUIRE: begin
                if (w_acq_slip)      w_next = S_SLIP;
                else if (w_lock_hit) w_next = S_LOCKED;
            end
            S_LOCKED:  if (w_unlock_hit) w_next = S_SLIP;
            S_SLIP:    w_next = S_FLUSH;
            default:   w_next = S_IDLE;
        endcase
        if (!i_cfg_en) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_llr_order <= '0;
            r_phase     <= 1'b0;
            r_slip_cnt  <= '0;
            r_flush_cnt <= '0;
            r_good_cnt  <= '0;
            r_err_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_win_cnt   <= '0;
            r_werr_cnt  <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE && i_cfg_en) r_llr_order <= i_cfg_llr_order;

            r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + FW'(1) : '0;

            if (r_state == S_ACQUIRE) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
                if (w_err) begin
                    r_err_cnt  <= r_err_cnt + EW'(1);
                    r_good_cnt <= '0;
                end else if (w_vld) begin
                    r_good_cnt <= r_good_cnt + GW'(1);
                end
            end else begin
                r_tmo_cnt  <= '0;
                r_err_cnt  <= '0;
                r_good_cnt <= '0;
            end

            if (r_state == S_LOCKED) begin
                if (w_wrap) begin
                    r_win_cnt  <= '0;
                    r_werr_cnt <= UW'(w_err);
                end else begin
                    if (w_vld) r_win_cnt  <= r_win_cnt + WW'(1);
                    if (w_err) r_werr_cnt <= r_werr_cnt + UW'(1);
                end
            end else begin
                r_win_cnt  <= '0;
                r_werr_cnt <= '0;
            end

            // Phase mirrors the deperforator flag, which toggles on every pulse it sees.
            if (r_state == S_SLIP) begin
                r_phase <= ~r_phase;
                if (r_slip_cnt != 8'hFF) r_slip_cnt <= r_slip_cnt + 8'd1;
            end
        end
    end

    assign dec_if.o_sh_pointer = (r_state == S_SLIP);
    assign dec_if.o_dec_rst_n  = (r_state != S_FLUSH);
    assign dec_if.o_llr_order  = r_llr_order;
    assign o_locked            = (r_state == S_LOCKED);
    assign o_phase             = r_phase;
    assign o_slip_cnt          = r_slip_cnt;

endmodule

// File: tb/tb_depunct_sync_ctrl.sv
// tb/tb_depunct_sync_ctrl.sv - randomized scoreboard bench for depunct_sync_ctrl
module tb_depunct_sync_ctrl;

    localparam int FLUSH_LEN   = 16;
    localparam int LOCK_CNT    = 256;
    localparam int ACQ_ERR_MAX = 4;
    localparam int TIMEOUT     = 4096;
    localparam int WIN         = 1024;
    localparam int UNLOCK_ERR  = 8;

    localparam int M_IDLE = 0, M_FLUSH = 1, M_ACQ = 2, M_LOCKED = 3, M_SLIP = 4;

    typedef struct packed {
        logic       sh;
        logic       dec_rst_n;
        logic       locked;
        logic       phase;
        logic [2:0] order;
        logic [7:0] slips;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_cfg_en;
    logic [2:0] i_cfg_llr_order;
    logic       o_locked;
    logic       o_phase;
    logic [7:0] o_slip_cnt;

    depunct_sync_ctrl_if dif ();

    depunct_sync_ctrl #(
        .FLUSH_LEN(FLUSH_LEN), .LOCK_CNT(LOCK_CNT), .ACQ_ERR_MAX(ACQ_ERR_MAX),
        .TIMEOUT(TIMEOUT), .WIN(WIN), .UNLOCK_ERR(UNLOCK_ERR)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_cfg_en        (i_cfg_en),
        .i_cfg_llr_order (i_cfg_llr_order),
        .dec_if          (dif),
        .o_locked        (o_locked),
        .o_phase         (o_phase),
        .o_slip_cnt      (o_slip_cnt)
    );

    always #5 clk = ~clk;

    obs_t q_exp[$];
    int   total = 0;
    int   bad   = 0;
    int   mon_cyc = 0;

    // Reference model: which phase of the search we are in and how far along it is.
    int m_mode = M_IDLE;
    int m_flush_left = 0;
    int m_run = 0;
    int m_errs = 0;
    int m_age = 0;
    int m_bits = 0;
    int m_werrs = 0;
    int m_phase = 0;
    int m_slips = 0;
    int m_order = 0;
    int cur_ord = 0;

    task automatic model_step(bit rn, bit en, bit [2:0] ord, bit vld, bit err);
        if (!rn) begin
            m_mode = M_IDLE; m_order = 0; m_phase = 0; m_slips = 0;
            return;
        end
        if (m_mode == M_SLIP) begin
            m_phase = 1 - m_phase;
            if (m_slips < 255) m_slips++;
        end
        if (!en) begin
            m_mode = M_IDLE;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_order = ord; m_mode = M_FLUSH; m_flush_left = FLUSH_LEN;
            end
            M_FLUSH: begin
                m_flush_left--;
                if (m_flush_left == 0) begin
                    m_mode = M_ACQ; m_run = 0; m_errs = 0; m_age = 0;
                end
            end
            M_ACQ: begin
                if (err) begin m_errs++; m_run = 0; end
                else if (vld) m_run++;
                if (m_errs == ACQ_ERR_MAX || m_age == TIMEOUT - 1) m_mode = M_SLIP;
                else if (m_run == LOCK_CNT) begin
                    m_mode = M_LOCKED; m_bits = 0; m_werrs = 0;
                end
                m_age++;
            end
            M_LOCKED: begin
                if (vld) m_bits++;
                if (m_bits == WIN) begin
                    m_bits = 0;
                    m_werrs = err ? 1 : 0;
                end else begin
                    if (err) m_werrs++;
                    if (m_werrs == UNLOCK_ERR) m_mode = M_SLIP;
                end
            end
            default: begin
                m_mode = M_FLUSH; m_flush_left = FLUSH_LEN;
            end
        endcase
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.sh        = (m_mode == M_SLIP);
        o.dec_rst_n = (m_mode != M_FLUSH);
        o.locked    = (m_mode == M_LOCKED);
        o.phase     = m_phase[0];
        o.order     = m_order[2:0];
        o.slips     = m_slips[7:0];
        return o;
    endfunction

    task automatic cycle(bit rn, bit en, bit [2:0] ord, bit vld, bit err);
        @(negedge clk);
        #1;
        reset_n         = rn;
        i_cfg_en        = en;
        i_cfg_llr_order = ord;
        dif.i_dec_vld   = vld;
        dif.i_dec_err   = err;
        model_step(rn, en, ord, vld, err);
        q_exp.push_back(model_obs());
    endtask

    task automatic run_rand(int n, int vld_pct, int err_pm, int endrop_pm, bit rand_order);
        for (int i = 0; i < n; i++) begin
            bit en, vld, err;
            bit [2:0] ord;
            en  = ($urandom_range(999) >= endrop_pm);
            vld = ($urandom_range(99) < vld_pct);
            err = ($urandom_range(999) < err_pm);
            ord = rand_order ? 3'($urandom) : 3'(cur_ord);
            cycle(1'b1, en, ord, vld, err);
        end
    endtask

    // Clean bit stream with errs_per_win errors spread through each locked window.
    task automatic run_window_errs(int nwin, int errs_per_win);
        int off;
        off = $urandom_range(127);
        for (int i = 0; i < nwin * WIN; i++) begin
            bit err;
            err = (m_mode == M_LOCKED) && ((m_bits % 128) == off) && ((m_bits / 128) < errs_per_win);
            cycle(1'b1, 1'b1, 3'(cur_ord), 1'b1, err);
        end
    endtask

    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            obs_t e, a;
            e = q_exp.pop_front();
            a = '{sh: dif.o_sh_pointer, dec_rst_n: dif.o_dec_rst_n, locked: o_locked,
                  phase: o_phase, order: dif.o_llr_order, slips: o_slip_cnt};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs cyc=%0d got sh=%b rstn=%b lk=%b ph=%b ord=%0d slips=%0d exp sh=%b rstn=%b lk=%b ph=%b ord=%0d slips=%0d",
                         mon_cyc, a.sh, a.dec_rst_n, a.locked, a.phase, a.order, a.slips,
                         e.sh, e.dec_rst_n, e.locked, e.phase, e.order, e.slips);
            end
            mon_cyc++;
        end
    end

    initial begin
        reset_n = 1'b0; i_cfg_en = 1'b1; i_cfg_llr_order = 3'd5;
        dif.i_dec_vld = 1'b0; dif.i_dec_err = 1'b0;

        cycle(1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'd5, 1'b0, 1'b0);

        cur_ord = 2;
        run_rand(300, 100, 0, 0, 1'b0);
        run_window_errs(3, 7);
        run_window_errs(1, 8);
        run_rand(200, 100, 0, 0, 1'b0);

        run_rand(2000, 100, 20, 0, 1'b0);
        run_rand(4200, 0, 0, 0, 1'b0);

        run_rand(20000, 70, 5, 3, 1'b1);
        run_rand(8000, 90, 2, 1, 1'b1);
        cur_ord = 6;
        cycle(1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
        run_rand(10000, 100, 300, 0, 1'b0);

        cur_ord = 3;
        cycle(1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
        run_rand(8, 100, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
        run_rand(300, 100, 0, 0, 1'b0);
        cycle(1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        run_rand(5, 100, 0, 0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #2;
        total++;
        if (q_exp.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
